fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the RISC-V pipeline; successor to the two-source, two-stage combinational forwarding logic. It tracks in-flight register writers across a configurable bypass window, resolves forwarding for the instruction in ID one cycle early and registers the result for EX, and generates load-use stalls for a configurable load latency. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
- ADDR_W, 5, register address width
- DEPTH, 3, number of bypass sources (select k = result bus k, k=1 is EX/MEM); legal 2..7
- LOAD_LAT, 1, extra cycles before load data reaches a bypass bus; legal 1..DEPTH-1
- CNT_W, 16, stall counter width
- SEL_W, $clog2(DEPTH+1), derived select width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze (memory wait); no state changes
- flush  in  1  redirect; kills ID and EX instructions this cycle
- id_rs1, id_rs2  in  ADDR_W  source registers of the ID instruction
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_valid  in  1  EX holds a real instruction (not a bubble)
- ex_rd  in  ADDR_W  EX destination
- ex_reg_write, ex_is_load  in  1  EX writes rd / EX is a load
- stall  out  1  hold PC and IF/ID, insert bubble into EX (combinational)
- fwd_a, fwd_b  out  SEL_W  registered bypass selects for the instruction in EX; 0 = register file
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Producer age: EX instruction = age 0 (from ports); internal shift register holds DEPTH-1 entries {valid, rd, wr, ld} for ages 1..DEPTH-1.
- Each cycle with hold=0: entry[0] <= {ex_valid & ~flush, ex_rd, ex_reg_write, ex_is_load}; entry[i] <= entry[i-1]; oldest dropped. Shifting continues during stall (EX becomes a bubble via ex_valid=0).
- Match for source s: valid & wr & rd==s & rd!=0 & s_used. Youngest match (smallest age a) wins; candidate select = a+1. No match -> 0. Producers older than the window are read from the register file (write-through assumed).
- Load-use: stall=1 if, for either used source, the youngest match is a load with age < LOAD_LAT. An older load is ignored when a younger non-load matches.
- flush forces stall=0. During rst_n=0, stall=0.
- fwd_a/fwd_b update when hold=0: candidate selects if stall=0 and flush=0; otherwise 0 (bubble enters EX).
- stall_cnt increments when stall=1 and hold=0; saturates at 2^CNT_W-1; never wraps.

## Timing
- Reset (async, rst_n low): all entries invalid, fwd_a=fwd_b=0, stall_cnt=0, stall=0.
- stall is same-cycle combinational from ports and entries; fwd_a/fwd_b valid one cycle after ID sampling, aligned with the instruction's EX cycle.
- Load in EX, dependent in ID: stall held for LOAD_LAT cycles; first non-stall cycle registers select LOAD_LAT+1.
- hold=1: entries, fwd_a/fwd_b, stall_cnt frozen; stall output still evaluated but not counted.
- flush and stall in the same cycle: flush wins; EX entry captured invalid.
- Reset mid-stall: stall drops immediately; first post-reset cycle sees an empty window.

## Test plan
- ADD x5 in EX (ex_reg_write=1), ID reads rs1=x5 -> stall=0; next cycle fwd_a=1, fwd_b=0.
- LOAD_LAT=1: LW x6 in EX, ID reads rs2=x6 -> stall=1 one cycle, fwd_b=0 next cycle; following cycle stall=0 and fwd_b=2; stall_cnt=1.
- x7 written at age 0 (ADD) and age 1 (LW) -> fwd_a=1, no stall; swap (LW age 0, ADD age 1) -> stall=1.
- ex_rd=x0 with ex_reg_write=1, ID reads x0 -> fwd_a=fwd_b=0, stall=0; id_rs1_used=0 with matching rs1 -> fwd_a=0.
- Load-use stall then hold=1 for 3 cycles -> entries, fwd, stall_cnt unchanged; after hold drops stall resolves per normal timing; then flush during a stall -> stall=0, fwd=0.
- CNT_W=4, force 20 stall cycles -> stall_cnt stops at 15; assert rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the RISC-V pipeline. The EX
// instruction is the age-0 producer (taken straight from the ports). A shift
// register holds the DEPTH-1 older producers (ages 1..DEPTH-1). For each
// source of the ID instruction the youngest matching producer selects bypass
// bus age+1. The select is registered so it lines up with the instruction's
// EX cycle. A match on a load younger than LOAD_LAT raises a load-use stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   hold                        global freeze; no state changes
//   flush                       redirect; kills the ID and EX instructions
//   id_rs1/id_rs2               ID source registers
//   id_rs1_used/id_rs2_used     source actually read
//   ex_valid, ex_rd             EX is a real instruction / its destination
//   ex_reg_write, ex_is_load    EX writes rd / EX is a load
//   stall                       combinational load-use stall
//   fwd_a, fwd_b                registered bypass selects for EX (0 = regfile)
//   stall_cnt                   saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic              ld;
  } entry_t;

  // r_ent[i] holds the producer of age i+1.
  entry_t            r_ent [DEPTH-1];
  logic [SEL_W-1:0]  r_fwd_a;
  logic [SEL_W-1:0]  r_fwd_b;
  logic [CNT_W-1:0]  r_cnt;

  // w_prod[a] is the producer of age a; age 0 is the live EX instruction.
  entry_t            w_prod [DEPTH];
  logic [ADDR_W-1:0] w_src  [2];
  logic              w_used [2];
  logic [SEL_W-1:0]  w_sel  [2];
  logic              w_haz  [2];

  always_comb begin
    w_prod[0] = '{valid: ex_valid, rd: ex_rd, wr: ex_reg_write, ld: ex_is_load};
    for (int i = 1; i < DEPTH; i++) begin
      w_prod[i] = r_ent[i-1];
    end
  end

  always_comb begin
    w_src[0]  = id_rs1;
    w_src[1]  = id_rs2;
    w_used[0] = id_rs1_used;
    w_used[1] = id_rs2_used;
  end

  // Scan from oldest to youngest so the youngest match is the last write.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise the tool infers a latch to hold the old value.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_sel[s] = '0;
      w_haz[s] = 1'b0;
      for (int a = DEPTH - 1; a >= 0; a--) begin
        if (w_prod[a].valid && w_prod[a].wr && (w_prod[a].rd == w_src[s]) &&
            (w_src[s] != '0) && w_used[s]) begin
          w_sel[s] = SEL_W'(a + 1);
          w_haz[s] = w_prod[a].ld && (a < LOAD_LAT);
        end
      end
    end
  end

  // Gated by rst_n so the stall drops the moment reset is asserted, even
  // while the EX ports still describe a load.
  assign stall = rst_n & ~flush & (w_haz[0] | w_haz[1]);

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of the others (the shift below depends on it).
  // NOTE: the producer window is a handful of flops, not a RAM, so it is
  // reset; a stale valid entry after reset would forward garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_ent[i] <= '0;
      end
      r_fwd_a <= '0;
      r_fwd_b <= '0;
      r_cnt   <= '0;
    end else if (!hold) begin
      r_ent[0] <= '{valid: ex_valid & ~flush, rd: ex_rd,
                    wr: ex_reg_write, ld: ex_is_load};
      for (int i = 1; i < DEPTH - 1; i++) begin
        r_ent[i] <= r_ent[i-1];
      end
      // A stalled or flushed ID instruction becomes a bubble in EX.
      if (stall || flush) begin
        r_fwd_a <= '0;
        r_fwd_b <= '0;
      end else begin
        r_fwd_a <= w_sel[0];
        r_fwd_b <= w_sel[1];
      end
      if (stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed scenarios followed by random traffic. Expected values come from a
// queue-based model of the producer history: the youngest writer of a source
// register within the window decides the bypass select and whether a load is
// still too young to forward.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int SEL_W    = $clog2(DEPTH + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              hold;
  logic              flush;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic              stall;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .flush       (flush),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_is_load  (ex_is_load),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } prod_t;

  prod_t hist[$];   // hist[0] is age 1
  int    m_fwd_a = 0;
  int    m_fwd_b = 0;
  int    m_cnt   = 0;
  bit    m_stall;
  logic  obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Youngest writer of src within the window decides select and hazard.
  function automatic void model_resolve(input int src, input bit used,
                                        output int sel, output bit haz);
    prod_t win[$];
    prod_t cur;
    sel = 0;
    haz = 1'b0;
    cur.v = ex_valid; cur.rd = int'(ex_rd); cur.wr = ex_reg_write; cur.ld = ex_is_load;
    win.push_back(cur);
    foreach (hist[i]) win.push_back(hist[i]);
    if (!used || src == 0) return;
    for (int a = 0; a < win.size(); a++) begin
      if (win[a].v && win[a].wr && win[a].rd == src) begin
        sel = a + 1;
        haz = win[a].ld && (a < LOAD_LAT);
        return;
      end
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_fwd_a = 0;
    m_fwd_b = 0;
    m_cnt   = 0;
  endfunction

  task automatic set_ex(input bit v, input int rd, input bit wr, input bit ld);
    ex_valid     = v;
    ex_rd        = rd[ADDR_W-1:0];
    ex_reg_write = wr;
    ex_is_load   = ld;
  endtask

  task automatic set_id(input int r1, input bit u1, input int r2, input bit u2);
    id_rs1      = r1[ADDR_W-1:0];
    id_rs1_used = u1;
    id_rs2      = r2[ADDR_W-1:0];
    id_rs2_used = u2;
  endtask

  // One clock: inputs are already driven at the negedge.
  task automatic step(input string tag);
    int  sa, sb;
    bit  ha, hb;
    prod_t p;
    #1;
    model_resolve(int'(id_rs1), id_rs1_used, sa, ha);
    model_resolve(int'(id_rs2), id_rs2_used, sb, hb);
    m_stall   = rst_n && !flush && (ha || hb);
    obs_stall = stall;
    chk({tag, "_stall"}, stall, m_stall);
    @(posedge clk);
    if (rst_n && !hold) begin
      p.v = ex_valid && !flush; p.rd = int'(ex_rd); p.wr = ex_reg_write; p.ld = ex_is_load;
      hist.push_front(p);
      if (hist.size() > DEPTH - 1) void'(hist.pop_back());
      m_fwd_a = (m_stall || flush) ? 0 : sa;
      m_fwd_b = (m_stall || flush) ? 0 : sb;
      if (m_stall && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    chk({tag, "_fwd_a"}, fwd_a, m_fwd_a);
    chk({tag, "_fwd_b"}, fwd_b, m_fwd_b);
    chk({tag, "_cnt"}, stall_cnt, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    set_ex(0, 0, 0, 0);
    set_id(0, 0, 0, 0);
    model_reset();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x5 in EX, ID reads x5 -> forward from EX/MEM
    set_ex(1, 5, 1, 0); set_id(5, 1, 0, 0);
    step("add");
    chk("add_stall_lit", obs_stall, 0);
    chk("add_fa_lit", fwd_a, 1);
    chk("add_fb_lit", fwd_b, 0);

    // LW x6 in EX, ID reads x6 -> one stall cycle, then select 2
    set_ex(1, 6, 1, 1); set_id(0, 0, 6, 1);
    step("lw1");
    chk("lw1_stall_lit", obs_stall, 1);
    chk("lw1_fb_lit", fwd_b, 0);
    set_ex(0, 0, 0, 0);
    step("lw2");
    chk("lw2_stall_lit", obs_stall, 0);
    chk("lw2_fb_lit", fwd_b, 2);
    chk("lw2_cnt_lit", stall_cnt, 1);

    // x7: ADD younger than LW -> forward, no stall
    set_ex(1, 7, 1, 1); set_id(0, 0, 0, 0);
    step("lwx7");
    set_ex(1, 7, 1, 0); set_id(7, 1, 0, 0);
    step("addx7");
    chk("addx7_stall_lit", obs_stall, 0);
    chk("addx7_fa_lit", fwd_a, 1);
    // swapped: LW younger than ADD -> stall
    set_ex(1, 7, 1, 0); set_id(0, 0, 0, 0);
    step("addx7b");
    set_ex(1, 7, 1, 1); set_id(7, 1, 0, 0);
    step("swap");
    chk("swap_stall_lit", obs_stall, 1);
    set_ex(0, 0, 0, 0); set_id(0, 0, 0, 0);
    step("drain");

    // x0 never forwards; unused source never forwards
    set_ex(1, 0, 1, 0); set_id(0, 1, 0, 1);
    step("x0");
    chk("x0_fa_lit", fwd_a, 0);
    chk("x0_fb_lit", fwd_b, 0);
    set_ex(1, 9, 1, 0); set_id(9, 0, 0, 0);
    step("unused");
    chk("unused_fa_lit", fwd_a, 0);

    // Load-use with hold for 3 cycles
    set_ex(1, 6, 1, 1); set_id(0, 0, 6, 1);
    hold = 1'b1;
    repeat (3) step("hold");
    hold = 1'b0;
    step("hold_rel");
    set_ex(0, 0, 0, 0);
    step("hold_bub");
    chk("hold_bub_fb_lit", fwd_b, 2);

    // Flush during a load-use stall
    set_ex(1, 6, 1, 1); set_id(0, 0, 6, 1);
    flush = 1'b1;
    step("flush");
    chk("flush_stall_lit", obs_stall, 0);
    chk("flush_fb_lit", fwd_b, 0);
    flush = 1'b0;
    set_ex(0, 0, 0, 0);
    step("post_flush");
    chk("post_flush_fb_lit", fwd_b, 0);

    // Saturation: 20 stall cycles
    set_ex(1, 6, 1, 1); set_id(0, 0, 6, 1);
    repeat (20) step("sat");
    chk("sat_cnt_lit", stall_cnt, CNT_MAX);

    // Reset mid-stall
    #1;
    chk("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_stall", stall, 0);
    chk("midrst_fwd_a", fwd_a, 0);
    chk("midrst_fwd_b", fwd_b, 0);
    chk("midrst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ex(0, 0, 0, 0); set_id(0, 0, 6, 1);
    step("post_rst");
    chk("post_rst_fb_lit", fwd_b, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_ex($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      set_id(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
